// File: rtl/sr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_pkg                                                                      |
// | Shared FSM state type, synchroniser depth and counter sizing helper.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } sr_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_w(input int max_v);
        int w;
        w = $clog2(max_v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_sync2                                                                    |
// | Two-flop synchroniser for asynchronous single-bit feedback, reset to 0.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sr_sync2
    import sr_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_cmd_gen                                                                  |
// | Set/reset pulse generator with readback; s and r are never high together.  |
// | Optional macro SR_SKIP_REDUNDANT_EN skips the pulse when q already matches.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int TMO     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CNT_MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_MAX    = (CNT_MAX_PG > TMO) ? CNT_MAX_PG : TMO;
    localparam int CNT_W      = cnt_w(CNT_MAX);

    sr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             s_q, s_d, r_q, r_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             q_sync;
    logic             w_accept;
    logic             w_skip;

    sr_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (q_fb),
        .q_o   (q_sync)
    );

    assign req_ready = (state_q == IDLE) & rst_n;
    assign w_accept  = req_valid & req_ready;

`ifdef SR_SKIP_REDUNDANT_EN
    assign w_skip = (q_sync == req_level);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Saturating count; every transition below clears it explicitly.
        cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    lvl_d   = req_level;
                    cnt_d   = '0;
                    state_d = w_skip ? CHECK : PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (GAP_W == 0) ? CHECK : GAP;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_W - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (q_sync == lvl_q) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TMO - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state so s/r are flop-driven and exclusive by construction.
        s_d    = (state_d == PULSE) &  lvl_d;
        r_d    = (state_d == PULSE) & ~lvl_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sr_cmd_gen                                                               |
// | Directed bench for sr_cmd_gen with a behavioural set/reset element model.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic req_ready, s, r, busy, done, err;
    logic q_fb = 1'b0;

    logic model_en = 1'b1;
    logic q_hold = 1'b0;

    int checks = 0;
    int failures = 0;
    int sr_viol = 0;
    int de_viol = 0;
    int acc_cnt = 0;
    int fin_cnt = 0;

    // Trace bit k holds the value seen in cycle k (cycle 1 follows accept edge 0).
    logic [15:0] t_s, t_r, t_busy, t_done, t_err, t_rdy;

    sr_cmd_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Storage element: set on s, clear on r, or forced to q_hold when the model is off.
    always @(posedge clk) begin
        if (!model_en)  q_fb <= q_hold;
        else if (s)     q_fb <= 1'b1;
        else if (r)     q_fb <= 1'b0;
    end

    always @(negedge clk) begin
        if (s & r)                   sr_viol++;
        if (done & err)              de_viol++;
        if (done | err)              fin_cnt++;
        if (req_valid & req_ready)   acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic lvl, input int n);
        t_s = '0; t_r = '0; t_busy = '0; t_done = '0; t_err = '0; t_rdy = '0;
        req_level = lvl;
        req_valid = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            t_s[k[3:0]] = s;       t_r[k[3:0]]    = r;
            t_busy[k[3:0]] = busy; t_done[k[3:0]] = done;
            t_err[k[3:0]] = err;   t_rdy[k[3:0]]  = req_ready;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_level = 1'b1;
        step(); step();
        checks++; if ({s, r, busy, done, err} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b want=00000", {s, r, busy, done, err});
        end
        checks++; if (req_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b want=0", req_ready);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_set();
        model_en = 1'b1;
        run_cmd(1'b1, 14);
        checks++; if (t_s !== 16'h0006) begin failures++; $display("FAIL set_s got=%h want=0006", t_s); end
        checks++; if (t_r !== 16'h0000) begin failures++; $display("FAIL set_r got=%h want=0000", t_r); end
        checks++; if (t_busy !== 16'h001E) begin failures++; $display("FAIL set_busy got=%h want=001e", t_busy); end
        checks++; if (t_done !== 16'h0020) begin failures++; $display("FAIL set_done got=%h want=0020", t_done); end
        checks++; if (t_err !== 16'h0000) begin failures++; $display("FAIL set_err got=%h want=0000", t_err); end
        checks++; if (t_rdy !== 16'h7FE0) begin failures++; $display("FAIL set_ready got=%h want=7fe0", t_rdy); end
    endtask

    task automatic test_reset_cmd();
        run_cmd(1'b0, 8);
        checks++; if (t_r !== 16'h0006) begin failures++; $display("FAIL rst_cmd_r got=%h want=0006", t_r); end
        checks++; if (t_s !== 16'h0000) begin failures++; $display("FAIL rst_cmd_s got=%h want=0000", t_s); end
        checks++; if (t_done !== 16'h0020) begin failures++; $display("FAIL rst_cmd_done got=%h want=0020", t_done); end
        checks++; if (t_err !== 16'h0000) begin failures++; $display("FAIL rst_cmd_err got=%h want=0000", t_err); end
        checks++; if (q_fb !== 1'b0) begin failures++; $display("FAIL rst_cmd_q got=%b want=0", q_fb); end
    endtask

    task automatic test_timeout();
        model_en = 1'b0; q_hold = 1'b0;
        step(); step(); step();
        run_cmd(1'b1, 14);
        checks++; if (t_s !== 16'h0006) begin failures++; $display("FAIL tmo_s got=%h want=0006", t_s); end
        checks++; if (t_r !== 16'h0000) begin failures++; $display("FAIL tmo_r got=%h want=0000", t_r); end
        checks++; if (t_err !== 16'h1000) begin failures++; $display("FAIL tmo_err got=%h want=1000", t_err); end
        checks++; if (t_done !== 16'h0000) begin failures++; $display("FAIL tmo_done got=%h want=0000", t_done); end
        checks++; if (t_busy !== 16'h0FFE) begin failures++; $display("FAIL tmo_busy got=%h want=0ffe", t_busy); end
        checks++; if (t_rdy !== 16'h7000) begin failures++; $display("FAIL tmo_ready got=%h want=7000", t_rdy); end
    endtask

    task automatic test_redundant();
        model_en = 1'b0; q_hold = 1'b1;
        step(); step(); step(); step();
        run_cmd(1'b1, 8);
`ifdef SR_SKIP_REDUNDANT_EN
        checks++; if (t_s !== 16'h0000) begin failures++; $display("FAIL redund_s got=%h want=0000", t_s); end
        checks++; if (t_done !== 16'h0004) begin failures++; $display("FAIL redund_done got=%h want=0004", t_done); end
        checks++; if (t_busy !== 16'h0002) begin failures++; $display("FAIL redund_busy got=%h want=0002", t_busy); end
`else
        checks++; if (t_s !== 16'h0006) begin failures++; $display("FAIL redund_s got=%h want=0006", t_s); end
        checks++; if (t_done !== 16'h0020) begin failures++; $display("FAIL redund_done got=%h want=0020", t_done); end
        checks++; if (t_busy !== 16'h001E) begin failures++; $display("FAIL redund_busy got=%h want=001e", t_busy); end
`endif
        checks++; if (t_r !== 16'h0000) begin failures++; $display("FAIL redund_r got=%h want=0000", t_r); end
    endtask

    task automatic test_reset_mid_pulse();
        int stray;
        stray = 0;
        q_hold = 1'b0;
        step(); step(); step(); step();
        model_en = 1'b1;
        req_level = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL mid_s_before got=%b want=1", s); end
        rst_n = 1'b0;
        step();
        checks++; if ({s, r, busy} !== 3'b000) begin
            failures++; $display("FAIL mid_outputs got=%b want=000", {s, r, busy});
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b want=0", req_ready); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (done | err) stray++;
            step();
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_no_finish got=%0d want=0", stray); end
        model_en = 1'b0; q_hold = 1'b0;
        step(); step(); step(); step();
        model_en = 1'b1;
        run_cmd(1'b1, 6);
        checks++; if (t_s !== 16'h0006) begin failures++; $display("FAIL mid_after_s got=%h want=0006", t_s); end
        checks++; if (t_done !== 16'h0020) begin failures++; $display("FAIL mid_after_done got=%h want=0020", t_done); end
    endtask

    task automatic test_back_to_back();
        t_s = '0; t_r = '0; t_busy = '0; t_done = '0; t_rdy = '0;
        req_level = 1'b0; req_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            t_s[k[3:0]] = s;       t_r[k[3:0]]    = r;
            t_busy[k[3:0]] = busy; t_done[k[3:0]] = done;
            t_rdy[k[3:0]] = req_ready;
            if (k == 1)  req_level = 1'b1;
            if (k == 10) req_valid = 1'b0;
        end
        step(); step();
        checks++; if (t_r !== 16'h0006) begin failures++; $display("FAIL b2b_r got=%h want=0006", t_r); end
        checks++; if (t_s !== 16'h00C0) begin failures++; $display("FAIL b2b_s got=%h want=00c0", t_s); end
        checks++; if (t_done !== 16'h0420) begin failures++; $display("FAIL b2b_done got=%h want=0420", t_done); end
        checks++; if (t_busy !== 16'h03DE) begin failures++; $display("FAIL b2b_busy got=%h want=03de", t_busy); end
        checks++; if (t_rdy !== 16'h0420) begin failures++; $display("FAIL b2b_ready got=%h want=0420", t_rdy); end
    endtask

    task automatic test_random();
        int acc0, fin0;
        model_en = 1'b1;
        acc0 = acc_cnt; fin0 = fin_cnt;
        for (int k = 0; k < 10000; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_level = 1'($urandom_range(0, 1));
            step();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();
        checks++; if ((acc_cnt - acc0) !== (fin_cnt - fin0)) begin
            failures++; $display("FAIL rand_accept_vs_finish got=%0d want=%0d", fin_cnt - fin0, acc_cnt - acc0);
        end
        checks++; if ((acc_cnt - acc0) < 100) begin
            failures++; $display("FAIL rand_activity got=%0d want>=100", acc_cnt - acc0);
        end
        checks++; if (sr_viol !== 0) begin failures++; $display("FAIL s_and_r got=%0d want=0", sr_viol); end
        checks++; if (de_viol !== 0) begin failures++; $display("FAIL done_and_err got=%0d want=0", de_viol); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_reset_cmd();
        test_timeout();
        test_redundant();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
